// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the RV32 5-stage pipeline hazard logic.
//   hz_state_e : hazard scheduler FSM states
//   REG_X0     : architectural zero register index
//   hz_ctl_t   : stall/flush bundle driven onto the F/D/E/M/W pipeline registers
//   HZ_*       : canned bundles for each hazard class
package pipe_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_X0 = '0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_WAIT  = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_e;

  // Field order is MSB first: stalls F..M, then flushes D..W.
  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_m;
    logic flush_w;
  } hz_ctl_t;

  localparam hz_ctl_t HZ_NONE = '0;

  // Data memory wait: freeze F..M, bubble into W.
  localparam hz_ctl_t HZ_MEM = '{stall_f: 1'b1, stall_d: 1'b1, stall_e: 1'b1,
                                 stall_m: 1'b1, flush_w: 1'b1, default: 1'b0};

  // Mul/div in EX: freeze F..E, bubble into M.
  localparam hz_ctl_t HZ_MD = '{stall_f: 1'b1, stall_d: 1'b1, stall_e: 1'b1,
                                flush_m: 1'b1, default: 1'b0};

  // Redirect from EX: squash the two younger instructions.
  localparam hz_ctl_t HZ_BR = '{flush_d: 1'b1, flush_e: 1'b1, default: 1'b0};

  // Load-use: hold F/D one cycle, bubble into E.
  localparam hz_ctl_t HZ_LU = '{stall_f: 1'b1, stall_d: 1'b1, flush_e: 1'b1,
                                default: 1'b0};

endpackage

// File: rtl/hazard_lu_detect.sv
// hazard_lu_detect: combinational load-use compare of the EX destination
// against every source operand of the ID instruction. Shared with the
// core's issue check.
//   rs     : ID source register indices, one per source slot
//   rs_use : ID instruction actually reads the slot
//   rd     : EX destination register
//   load   : EX instruction is a load
//   hazard : at least one read source depends on the in-flight load
module hazard_lu_detect
  import pipe_pkg::*;
#(
  parameter int NUM_SRC = 2
) (
  input  logic [NUM_SRC-1:0][REG_W-1:0] rs,
  input  logic [NUM_SRC-1:0]            rs_use,
  input  logic [REG_W-1:0]              rd,
  input  logic                          load,
  output logic                          hazard
);

  logic [NUM_SRC-1:0] hit;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign hit[i] = rs_use[i] && (rs[i] == rd);
  end

  // x0 is hardwired zero, so a load "to" it never produces a dependency.
  assign hazard = load && (rd != REG_X0) && (|hit);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: central stall/flush scheduler for the 5-stage RV32 pipeline.
// Detects load-use hazards, freezes the pipe for multi-cycle mul/div in EX
// and for data-memory wait states in MEM, and issues redirect flushes.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   rs1d/rs2d, rs1d_use/rs2d_use  ID sources and their use flags
//   rde, load_e                EX destination and load flag
//   branch_taken_e             EX redirect
//   md_start_e, md_done        mul/div launch / result-valid pulses
//   mem_req_m, dmem_ready      MEM access and data-memory completion
//   stall_f/d/e/m              hold pipeline registers
//   flush_d/e/m/w              load bubbles into pipeline registers
//   md_busy                    FSM is in MD_WAIT
//   md_timeout                 sticky: mul/div exceeded MD_MAX_CYC
//   perf_lu_cnt/perf_md_cnt/perf_mem_cnt  stall-cycle counters, only when
//                              HAZARD_PERF_EN is defined
//
// Optional feature macro: HAZARD_PERF_EN.
// CNT_W must satisfy 2**CNT_W > MD_MAX_CYC.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MD_MAX_CYC = 40,
  parameter int CNT_W      = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] rs1d,
  input  logic [REG_W-1:0] rs2d,
  input  logic             rs1d_use,
  input  logic             rs2d_use,
  input  logic [REG_W-1:0] rde,
  input  logic             load_e,
  input  logic             branch_taken_e,
  input  logic             md_start_e,
  input  logic             md_done,
  input  logic             mem_req_m,
  input  logic             dmem_ready,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_m,
  output logic             flush_w,
  output logic             md_busy,
  output logic             md_timeout
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]      perf_lu_cnt,
  output logic [31:0]      perf_md_cnt,
  output logic [31:0]      perf_mem_cnt
`endif
);

  localparam logic [CNT_W-1:0] MD_MAX = CNT_W'(MD_MAX_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  hz_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             md_pend, md_pend_nxt;   // mul/div launched, not yet retired
  logic             md_seen, md_seen_nxt;   // md_done arrived while frozen on memory
  logic             tmo_set;
  logic             lu_haz, lu_stall;
  logic             mem_stall, md_fin;
  hz_ctl_t          ctl, ctl_o;

  hazard_lu_detect #(.NUM_SRC(2)) u_lu (
    .rs     ({rs2d, rs1d}),
    .rs_use ({rs2d_use, rs1d_use}),
    .rd     (rde),
    .load   (load_e),
    .hazard (lu_haz)
  );

  assign mem_stall = mem_req_m && !dmem_ready;
  assign md_fin    = md_done || md_seen;

  always_comb begin
    ctl         = HZ_NONE;
    state_nxt   = state;
    cnt_nxt     = cnt;
    md_pend_nxt = md_pend;
    md_seen_nxt = md_seen;
    lu_stall    = 1'b0;
    case (state)
      RUN: begin
        if (mem_stall) begin
          ctl       = HZ_MEM;
          state_nxt = MEM_WAIT;
          // The start pulse is single-cycle; remember it so the op is
          // resumed once memory releases the pipe.
          if (md_start_e) begin
            md_pend_nxt = 1'b1;
            cnt_nxt     = CNT_ONE;
          end
        end else if (md_start_e) begin
          ctl         = HZ_MD;
          state_nxt   = MD_WAIT;
          md_pend_nxt = 1'b1;
          cnt_nxt     = CNT_ONE;
        end else if (branch_taken_e) begin
          // ID instruction is squashed, so any load-use on it is moot.
          ctl = HZ_BR;
        end else if (lu_haz) begin
          ctl      = HZ_LU;
          lu_stall = 1'b1;
        end
        // A stray md_done here has no pending op and is ignored.
      end
      MD_WAIT: begin
        if (mem_stall) begin
          ctl       = HZ_MEM;
          state_nxt = MEM_WAIT;
          if (md_done) md_seen_nxt = 1'b1;
        end else if (md_fin) begin
          state_nxt   = RUN;
          md_pend_nxt = 1'b0;
          md_seen_nxt = 1'b0;
          cnt_nxt     = '0;
        end else begin
          ctl = HZ_MD;
          if (cnt != MD_MAX) cnt_nxt = cnt + CNT_ONE;
        end
      end
      MEM_WAIT: begin
        if (md_done && md_pend) md_seen_nxt = 1'b1;
        if (!dmem_ready) begin
          ctl = HZ_MEM;
        end else if (md_pend) begin
          state_nxt = MD_WAIT;
          // Result not in yet: keep the mul/div held in EX across the
          // hand-back so it is not released a cycle early.
          if (!md_fin) ctl = HZ_MD;
        end else begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // Flag as soon as the wait counter would read MD_MAX with the op outstanding.
  assign tmo_set = md_pend_nxt && (cnt_nxt == MD_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      cnt        <= '0;
      md_pend    <= 1'b0;
      md_seen    <= 1'b0;
      md_timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      md_pend <= md_pend_nxt;
      md_seen <= md_seen_nxt;
      if (tmo_set) md_timeout <= 1'b1;
    end
  end

  // Outputs drop the instant reset asserts, independent of the inputs.
  assign ctl_o   = rst_n ? ctl : HZ_NONE;
  assign stall_f = ctl_o.stall_f;
  assign stall_d = ctl_o.stall_d;
  assign stall_e = ctl_o.stall_e;
  assign stall_m = ctl_o.stall_m;
  assign flush_d = ctl_o.flush_d;
  assign flush_e = ctl_o.flush_e;
  assign flush_m = ctl_o.flush_m;
  assign flush_w = ctl_o.flush_w;
  assign md_busy = (state == MD_WAIT);

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_lu_cnt  <= '0;
      perf_md_cnt  <= '0;
      perf_mem_cnt <= '0;
    end else begin
      if (lu_stall)            perf_lu_cnt  <= perf_lu_cnt + 32'd1;
      if (state == MD_WAIT)    perf_md_cnt  <= perf_md_cnt + 32'd1;
      if (state == MEM_WAIT)   perf_mem_cnt <= perf_mem_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed bench for hazard_ctrl (MD_MAX_CYC = 8).
// Each step queues its expected output bundle and pops it when the cycle's
// combinational outputs are sampled on the falling edge.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1d, rs2d, rde;
  logic       rs1d_use, rs2d_use, load_e, branch_taken_e;
  logic       md_start_e, md_done, mem_req_m, dmem_ready;
  logic       stall_f, stall_d, stall_e, stall_m;
  logic       flush_d, flush_e, flush_m, flush_w;
  logic       md_busy, md_timeout;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_lu_cnt, perf_md_cnt, perf_mem_cnt;
`endif

  hazard_ctrl #(.MD_MAX_CYC(8), .CNT_W(6)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rs1d           (rs1d),
    .rs2d           (rs2d),
    .rs1d_use       (rs1d_use),
    .rs2d_use       (rs2d_use),
    .rde            (rde),
    .load_e         (load_e),
    .branch_taken_e (branch_taken_e),
    .md_start_e     (md_start_e),
    .md_done        (md_done),
    .mem_req_m      (mem_req_m),
    .dmem_ready     (dmem_ready),
    .stall_f        (stall_f),
    .stall_d        (stall_d),
    .stall_e        (stall_e),
    .stall_m        (stall_m),
    .flush_d        (flush_d),
    .flush_e        (flush_e),
    .flush_m        (flush_m),
    .flush_w        (flush_w),
    .md_busy        (md_busy),
    .md_timeout     (md_timeout)
`ifdef HAZARD_PERF_EN
    ,
    .perf_lu_cnt    (perf_lu_cnt),
    .perf_md_cnt    (perf_md_cnt),
    .perf_mem_cnt   (perf_mem_cnt)
`endif
  );

  always #5 clk = ~clk;

  // ctl order: stall_f stall_d stall_e stall_m flush_d flush_e flush_m flush_w
  localparam logic [7:0] O_NONE = 8'b0000_0000;
  localparam logic [7:0] O_MEM  = 8'b1111_0001;
  localparam logic [7:0] O_MD   = 8'b1110_0010;
  localparam logic [7:0] O_BR   = 8'b0000_1100;
  localparam logic [7:0] O_LU   = 8'b1100_0100;

  typedef struct packed {
    logic [7:0] ctl;
    logic       busy;
    logic       tmo;
  } exp_t;

  exp_t  sb[$];
  string tq[$];
  int    n_chk = 0, n_pass = 0, n_fail = 0;

  task automatic expect_out(input string tag, input logic [7:0] c, input logic b, input logic t);
    exp_t e;
    e.ctl  = c;
    e.busy = b;
    e.tmo  = t;
    sb.push_back(e);
    tq.push_back(tag);
  endtask

  task automatic check_out();
    exp_t  e, o;
    string tag;
    n_chk++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty: observed no queued expectation, expected one");
      return;
    end
    e = sb.pop_front();
    tag = tq.pop_front();
    o.ctl  = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w};
    o.busy = md_busy;
    o.tmo  = md_timeout;
    assert (o === e) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed ctl=%b busy=%b tmo=%b, expected ctl=%b busy=%b tmo=%b",
             tag, o.ctl, o.busy, o.tmo, e.ctl, e.busy, e.tmo);
    end
  endtask

  // Inputs are already set for this cycle; sample mid-cycle, then advance.
  task automatic cyc(input string tag, input logic [7:0] c, input logic b, input logic t);
    expect_out(tag, c, b, t);
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rs1d = '0; rs2d = '0; rde = '0;
    rs1d_use = 1'b0; rs2d_use = 1'b0; load_e = 1'b0; branch_taken_e = 1'b0;
    md_start_e = 1'b0; md_done = 1'b0; mem_req_m = 1'b0; dmem_ready = 1'b0;
  endtask

  initial begin
    // Reset held with hazard-provoking inputs: outputs must stay low.
    rst_n = 1'b0;
    clr();
    mem_req_m = 1'b1; load_e = 1'b1; rde = 5'd5; rs1d = 5'd5; rs1d_use = 1'b1;
    @(negedge clk);
    expect_out("rst_hold", O_NONE, 1'b0, 1'b0);
    check_out();
    @(posedge clk); #1;
    rst_n = 1'b1;
    clr();
    cyc("idle", O_NONE, 1'b0, 1'b0);

    // Load-use on rs1, one cycle only.
    load_e = 1'b1; rde = 5'd5; rs1d = 5'd5; rs1d_use = 1'b1;
    cyc("lu_rs1", O_LU, 1'b0, 1'b0);
    load_e = 1'b0; rde = 5'd0;
    cyc("lu_once", O_NONE, 1'b0, 1'b0);
    // Load-use on rs2; then same match with the source unused.
    clr(); load_e = 1'b1; rde = 5'd7; rs1d = 5'd3; rs1d_use = 1'b1; rs2d = 5'd7; rs2d_use = 1'b1;
    cyc("lu_rs2", O_LU, 1'b0, 1'b0);
    rs2d_use = 1'b0;
    cyc("lu_nouse", O_NONE, 1'b0, 1'b0);
    // x0 never stalls.
    clr(); load_e = 1'b1; rde = 5'd0; rs1d = 5'd0; rs1d_use = 1'b1; rs2d = 5'd0; rs2d_use = 1'b1;
    cyc("lu_x0", O_NONE, 1'b0, 1'b0);
    // Matching registers but EX is not a load.
    clr(); rde = 5'd5; rs1d = 5'd5; rs1d_use = 1'b1;
    cyc("lu_noload", O_NONE, 1'b0, 1'b0);
    // Branch suppresses a simultaneous load-use.
    load_e = 1'b1; branch_taken_e = 1'b1;
    cyc("br_lu", O_BR, 1'b0, 1'b0);
    clr(); branch_taken_e = 1'b1;
    cyc("br_only", O_BR, 1'b0, 1'b0);

    // Mul/div beats load-use; done after 6 wait cycles -> 7 stall cycles.
    clr(); md_start_e = 1'b1; load_e = 1'b1; rde = 5'd5; rs1d = 5'd5; rs1d_use = 1'b1;
    cyc("md_start", O_MD, 1'b0, 1'b0);
    clr();
    for (int i = 1; i <= 6; i++) cyc("md_wait", O_MD, 1'b1, 1'b0);
    md_done = 1'b1;
    cyc("md_done", O_NONE, 1'b1, 1'b0);
    clr();
    cyc("md_run", O_NONE, 1'b0, 1'b0);

    // Memory wait 3 cycles, with a stray md_done (no op pending) mid-wait.
    mem_req_m = 1'b1;
    for (int i = 0; i < 3; i++) begin
      md_done = (i == 1);
      cyc("mem_wait", O_MEM, 1'b0, 1'b0);
    end
    md_done = 1'b0; dmem_ready = 1'b1;
    cyc("mem_ready", O_NONE, 1'b0, 1'b0);
    clr();
    cyc("mem_run", O_NONE, 1'b0, 1'b0);
    // The stray pulse must not complete the next mul/div early.
    md_start_e = 1'b1;
    cyc("md2_start", O_MD, 1'b0, 1'b0);
    clr();
    cyc("md2_nostale", O_MD, 1'b1, 1'b0);
    md_done = 1'b1;
    cyc("md2_done", O_NONE, 1'b1, 1'b0);
    clr();
    cyc("md2_run", O_NONE, 1'b0, 1'b0);

    // Overlap: memory stall inside MD_WAIT, md_done during MEM_WAIT.
    md_start_e = 1'b1;
    cyc("ov_start", O_MD, 1'b0, 1'b0);
    clr();
    cyc("ov_wait", O_MD, 1'b1, 1'b0);
    mem_req_m = 1'b1;
    cyc("ov_memin", O_MEM, 1'b1, 1'b0);
    md_done = 1'b1;
    cyc("ov_done", O_MEM, 1'b0, 1'b0);
    md_done = 1'b0;
    cyc("ov_memhold", O_MEM, 1'b0, 1'b0);
    dmem_ready = 1'b1;
    cyc("ov_ready", O_NONE, 1'b0, 1'b0);
    clr();
    cyc("ov_pass", O_NONE, 1'b1, 1'b0);
    cyc("ov_run", O_NONE, 1'b0, 1'b0);

    // Timeout: no md_done, flag rises at cycle 8 and stays.
    md_start_e = 1'b1;
    cyc("tmo_start", O_MD, 1'b0, 1'b0);
    clr();
    for (int i = 1; i <= 7; i++) cyc("tmo_pre", O_MD, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc("tmo_set", O_MD, 1'b1, 1'b1);

    // Reset asserted mid-stall, away from any clock edge.
    mem_req_m = 1'b1;
    #1;
    expect_out("pre_rst", O_MEM, 1'b1, 1'b1);
    check_out();
    rst_n = 1'b0;
    #1;
    expect_out("rst_async", O_NONE, 1'b0, 1'b0);
    check_out();
    @(posedge clk); #1;
    rst_n = 1'b1;
    clr();
    cyc("rst_idle", O_NONE, 1'b0, 1'b0);
    load_e = 1'b1; rde = 5'd9; rs2d = 5'd9; rs2d_use = 1'b1;
    cyc("rst_lu", O_LU, 1'b0, 1'b0);
    clr();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
